time_set_ctrl: RTL and testbench

//  Front-panel time-setting controller that drives the timekeeper's load interface (i_hours, i_minutes, set_time_flag).

---
 rtl/clock_pkg.sv | 24 ++
 rtl/time_set_ctrl_btn_sync_edge.sv | 46 ++++
 rtl/time_set_ctrl.sv | 157 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared clock-domain definitions for the timekeeper and its front-panel controls.
// Field widths, value limits, edit FSM encoding and the edit_field display codes.
package clock_pkg;

    localparam int HOURS_W = 5;
    localparam int MIN_W   = 6;

    localparam logic [HOURS_W-1:0] MAX_HOUR = HOURS_W'(23);
    localparam logic [MIN_W-1:0]   MAX_MIN  = MIN_W'(59);

    // State codes double as the edit_field display codes.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EDIT_H = 2'b01,
        ST_EDIT_M = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    localparam logic [1:0] FIELD_IDLE   = 2'b00;
    localparam logic [1:0] FIELD_HOURS  = 2'b01;
    localparam logic [1:0] FIELD_MIN    = 2'b10;
    localparam logic [1:0] FIELD_COMMIT = 2'b11;

endpackage

// File: rtl/time_set_ctrl_btn_sync_edge.sv
// Raw button -> 2-flop synchroniser, rising-edge detect and optional hold auto-repeat.
// step is one cycle wide; a rise sampled at edge k produces a step acted on at edge k+2.
module btn_sync_edge #(
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic step_o
);

    localparam int CW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          prev_q;
    logic [CW-1:0] rpt_q;
    logic [CW-1:0] rpt_d;

    // Phase counter runs only while the synced level is high; it is zero on the edge cycle.
    always_comb begin
        rpt_d = '0;
        if (sync2_q) begin
            rpt_d = (rpt_q == RPT_LAST) ? '0 : rpt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rpt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rpt_q   <= rpt_d;
        end
    end

    assign step_o = sync2_q & (~prev_q | (REPEAT_EN & (rpt_q == '0)));

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: capture, edit hours, edit minutes, commit to timekeeper.
// Commit is a one-cycle set_time_flag with set_hours/set_minutes held stable around it.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int REPEAT_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic [HOURS_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]   cur_minutes,
    output logic [HOURS_W-1:0] set_hours,
    output logic [MIN_W-1:0]   set_minutes,
    output logic               set_time_flag,
    output logic [1:0]         edit_field
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic mode_step;
    logic inc_step;
    logic dec_step;

    btn_sync_edge #(.REPEAT_EN(1'b0), .REPEAT_CYCLES(REPEAT_CYCLES)) u_mode (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_mode),
        .step_o (mode_step)
    );

    btn_sync_edge #(.REPEAT_EN(1'b1), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_inc),
        .step_o (inc_step)
    );

    btn_sync_edge #(.REPEAT_EN(1'b1), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_dec),
        .step_o (dec_step)
    );

    state_t             state_q;
    logic [HOURS_W-1:0] hours_q;
    logic [MIN_W-1:0]   mins_q;
    logic               flag_q;
    logic [1:0]         field_q;
    logic [TW-1:0]      tmo_q;

    logic [HOURS_W-1:0] hours_up;
    logic [HOURS_W-1:0] hours_dn;
    logic [MIN_W-1:0]   mins_up;
    logic [MIN_W-1:0]   mins_dn;
    logic [HOURS_W-1:0] cap_hours;
    logic [MIN_W-1:0]   cap_mins;
    logic               adj_up;
    logic               adj_dn;
    logic               adj_any;

    // Wrap at the field limits with explicit compares so values never leave their range.
    always_comb begin
        hours_up  = (hours_q == MAX_HOUR) ? '0 : hours_q + 1'b1;
        hours_dn  = (hours_q == '0) ? MAX_HOUR : hours_q - 1'b1;
        mins_up   = (mins_q == MAX_MIN) ? '0 : mins_q + 1'b1;
        mins_dn   = (mins_q == '0) ? MAX_MIN : mins_q - 1'b1;
        cap_hours = (cur_hours > MAX_HOUR) ? '0 : cur_hours;
        cap_mins  = (cur_minutes > MAX_MIN) ? '0 : cur_minutes;
        adj_up    = inc_step & ~dec_step;
        adj_dn    = dec_step & ~inc_step;
        adj_any   = inc_step | dec_step;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hours_q <= '0;
            mins_q  <= '0;
            flag_q  <= 1'b0;
            field_q <= FIELD_IDLE;
            tmo_q   <= '0;
        end else begin
            flag_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mode_step) begin
                        state_q <= ST_EDIT_H;
                        field_q <= FIELD_HOURS;
                        hours_q <= cap_hours;
                        mins_q  <= cap_mins;
                        tmo_q   <= '0;
                    end
                end
                ST_EDIT_H: begin
                    if (mode_step) begin
                        state_q <= ST_EDIT_M;
                        field_q <= FIELD_MIN;
                        tmo_q   <= '0;
                    end else if (adj_any) begin
                        tmo_q <= '0;
                        if (adj_up) begin
                            hours_q <= hours_up;
                        end else if (adj_dn) begin
                            hours_q <= hours_dn;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ST_IDLE;
                        field_q <= FIELD_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_EDIT_M: begin
                    if (mode_step) begin
                        state_q <= ST_COMMIT;
                        field_q <= FIELD_COMMIT;
                        flag_q  <= 1'b1;
                        tmo_q   <= '0;
                    end else if (adj_any) begin
                        tmo_q <= '0;
                        if (adj_up) begin
                            mins_q <= mins_up;
                        end else if (adj_dn) begin
                            mins_q <= mins_dn;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ST_IDLE;
                        field_q <= FIELD_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    // Events arriving while the strobe is out are dropped.
                    state_q <= ST_IDLE;
                    field_q <= FIELD_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    field_q <= FIELD_IDLE;
                end
            endcase
        end
    end

    assign set_hours     = hours_q;
    assign set_minutes   = mins_q;
    assign set_time_flag = flag_q;
    assign edit_field    = field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized edit sessions.
module tb_time_set_ctrl;

    localparam int T = 30;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [4:0] cur_hours = '0;
    logic [5:0] cur_minutes = '0;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic       set_time_flag;
    logic [1:0] edit_field;

    int n_chk = 0;
    int n_fail = 0;

    int   flag_cnt = 0;
    int   dbl_cnt = 0;
    int   flag_h = 0, flag_m = 0, pre_h = 0, pre_m = 0, post_h = 0, post_m = 0;
    int   last_h = 0, last_m = 0;
    logic prev_flag = 1'b0;
    logic post_pend = 1'b0;

    time_set_ctrl #(.TIMEOUT_CYCLES(T), .REPEAT_CYCLES(R)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .btn_dec       (btn_dec),
        .cur_hours     (cur_hours),
        .cur_minutes   (cur_minutes),
        .set_hours     (set_hours),
        .set_minutes   (set_minutes),
        .set_time_flag (set_time_flag),
        .edit_field    (edit_field)
    );

    always #5 clk = ~clk;

    // Records each strobe with the load values the cycle before, during and after it.
    always @(negedge clk) begin
        if (post_pend) begin
            post_h = int'(set_hours);
            post_m = int'(set_minutes);
            post_pend = 1'b0;
        end
        if (set_time_flag === 1'b1) begin
            flag_cnt++;
            if (prev_flag === 1'b1) dbl_cnt++;
            flag_h = int'(set_hours);
            flag_m = int'(set_minutes);
            pre_h = last_h;
            pre_m = last_m;
            post_pend = 1'b1;
        end
        prev_flag = set_time_flag;
        last_h = int'(set_hours);
        last_m = int'(set_minutes);
    end

    function automatic int wrap(input int v, input int delta, input int n);
        return ((v + delta) % n + n) % n;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i, input logic d, input int hold, input int gap);
        btn_mode = m;
        btn_inc = i;
        btn_dec = d;
        tick(hold);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        tick(gap);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_chk++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL reset_field: got %0d expected 0", edit_field); end
        n_chk++; if (set_hours !== 5'd0) begin n_fail++; $display("FAIL reset_hours: got %0d expected 0", set_hours); end
        n_chk++; if (set_minutes !== 6'd0) begin n_fail++; $display("FAIL reset_minutes: got %0d expected 0", set_minutes); end
        n_chk++; if (set_time_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %0d expected 0", set_time_flag); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid_edit();
        int base;
        cur_hours = 5'd7;
        cur_minutes = 6'd45;
        press(1, 0, 0, 1, 3);
        press(1, 0, 0, 1, 3);
        n_chk++; if (edit_field !== 2'd2) begin n_fail++; $display("FAIL midrst_pre_field: got %0d expected 2", edit_field); end
        n_chk++; if (set_minutes !== 6'd45) begin n_fail++; $display("FAIL midrst_pre_min: got %0d expected 45", set_minutes); end
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL midrst_field: got %0d expected 0", edit_field); end
        n_chk++; if (set_hours !== 5'd0) begin n_fail++; $display("FAIL midrst_hours: got %0d expected 0", set_hours); end
        n_chk++; if (set_minutes !== 6'd0) begin n_fail++; $display("FAIL midrst_minutes: got %0d expected 0", set_minutes); end
        n_chk++; if (set_time_flag !== 1'b0) begin n_fail++; $display("FAIL midrst_flag: got %0d expected 0", set_time_flag); end
        tick(1);
        rst = 1'b1;
        base = flag_cnt;
        tick(50);
        n_chk++; if (flag_cnt !== base) begin n_fail++; $display("FAIL midrst_noflag: got %0d flags expected %0d", flag_cnt, base); end
        n_chk++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL midrst_idle: got %0d expected 0", edit_field); end
    endtask

    task automatic test_sequence();
        int base;
        cur_hours = 5'd10;
        cur_minutes = 6'd30;
        base = flag_cnt;
        press(1, 0, 0, 1, 2);
        press(0, 1, 0, 1, 2);
        press(0, 1, 0, 1, 2);
        press(1, 0, 0, 1, 2);
        press(0, 0, 1, 1, 2);
        press(1, 0, 0, 1, 2);
        tick(3);
        n_chk++; if (flag_cnt !== base + 1) begin n_fail++; $display("FAIL seq_flag_count: got %0d expected %0d", flag_cnt, base + 1); end
        n_chk++; if (flag_h !== 12 || flag_m !== 29) begin n_fail++; $display("FAIL seq_values: got %0d:%0d expected 12:29", flag_h, flag_m); end
        n_chk++; if (pre_h !== 12 || pre_m !== 29 || post_h !== 12 || post_m !== 29) begin
            n_fail++; $display("FAIL seq_stable: got pre %0d:%0d post %0d:%0d expected 12:29", pre_h, pre_m, post_h, post_m);
        end
        n_chk++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL seq_idle: got %0d expected 0", edit_field); end
    endtask

    task automatic test_wrap();
        cur_hours = 5'd23;
        cur_minutes = 6'd59;
        press(1, 0, 0, 1, 3);
        n_chk++; if (set_hours !== 5'd23) begin n_fail++; $display("FAIL wrap_cap: got %0d expected 23", set_hours); end
        press(0, 1, 0, 1, 3);
        n_chk++; if (set_hours !== 5'd0) begin n_fail++; $display("FAIL wrap_h_inc: got %0d expected 0", set_hours); end
        press(0, 0, 1, 1, 3);
        n_chk++; if (set_hours !== 5'd23) begin n_fail++; $display("FAIL wrap_h_dec: got %0d expected 23", set_hours); end
        press(1, 0, 0, 1, 3);
        press(0, 1, 0, 1, 3);
        n_chk++; if (set_minutes !== 6'd0) begin n_fail++; $display("FAIL wrap_m_inc: got %0d expected 0", set_minutes); end
        press(0, 0, 1, 1, 3);
        n_chk++; if (set_minutes !== 6'd59) begin n_fail++; $display("FAIL wrap_m_dec: got %0d expected 59", set_minutes); end
        press(1, 0, 0, 1, 3);
        n_chk++; if (flag_h !== 23 || flag_m !== 59) begin n_fail++; $display("FAIL wrap_commit: got %0d:%0d expected 23:59", flag_h, flag_m); end
        cur_hours = 5'd30;
        cur_minutes = 6'd62;
        press(1, 0, 0, 1, 3);
        n_chk++; if (set_hours !== 5'd0) begin n_fail++; $display("FAIL wrap_cap_h30: got %0d expected 0", set_hours); end
        n_chk++; if (set_minutes !== 6'd0) begin n_fail++; $display("FAIL wrap_cap_m62: got %0d expected 0", set_minutes); end
        press(1, 0, 0, 1, 3);
        press(1, 0, 0, 1, 3);
    endtask

    task automatic test_timeout();
        int base;
        cur_hours = 5'd4;
        cur_minutes = 6'd17;
        base = flag_cnt;
        btn_mode = 1'b1; tick(1); btn_mode = 1'b0; tick(2);
        n_chk++; if (edit_field !== 2'd1 || set_hours !== 5'd4) begin n_fail++; $display("FAIL tmo_enter: got field %0d hours %0d expected 1 4", edit_field, set_hours); end
        tick(T - 1);
        n_chk++; if (edit_field !== 2'd1) begin n_fail++; $display("FAIL tmo_last_cycle: got %0d expected 1", edit_field); end
        tick(1);
        n_chk++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL tmo_expire: got %0d expected 0", edit_field); end
        n_chk++; if (set_hours !== 5'd4 || set_minutes !== 6'd17) begin n_fail++; $display("FAIL tmo_keep: got %0d:%0d expected 4:17", set_hours, set_minutes); end
        n_chk++; if (flag_cnt !== base) begin n_fail++; $display("FAIL tmo_noflag: got %0d expected %0d", flag_cnt, base); end
        btn_mode = 1'b1; tick(1); btn_mode = 1'b0; tick(2);
        tick(T - 4);
        btn_inc = 1'b1; tick(1); btn_inc = 1'b0; tick(2);
        n_chk++; if (edit_field !== 2'd1 || set_hours !== 5'd5) begin n_fail++; $display("FAIL tmo_late_press: got field %0d hours %0d expected 1 5", edit_field, set_hours); end
        tick(T - 1);
        n_chk++; if (edit_field !== 2'd1) begin n_fail++; $display("FAIL tmo_restart: got %0d expected 1", edit_field); end
        tick(1);
        n_chk++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL tmo_restart_expire: got %0d expected 0", edit_field); end
    endtask

    task automatic test_simultaneous();
        int base;
        cur_hours = 5'd10;
        cur_minutes = 6'd20;
        press(1, 0, 0, 1, 3);
        press(0, 1, 1, 1, 3);
        n_chk++; if (set_hours !== 5'd10) begin n_fail++; $display("FAIL sim_incdec: got %0d expected 10", set_hours); end
        press(1, 1, 0, 1, 3);
        n_chk++; if (edit_field !== 2'd2 || set_hours !== 5'd10) begin n_fail++; $display("FAIL sim_mode_inc: got field %0d hours %0d expected 2 10", edit_field, set_hours); end
        base = flag_cnt;
        btn_mode = 1'b1; tick(1);
        btn_mode = 1'b0; btn_inc = 1'b1; tick(1);
        btn_inc = 1'b0; tick(4);
        n_chk++; if (flag_cnt !== base + 1 || flag_m !== 20) begin n_fail++; $display("FAIL sim_commit: got %0d flags min %0d expected %0d 20", flag_cnt, flag_m, base + 1); end
        n_chk++; if (set_minutes !== 6'd20 || edit_field !== 2'd0) begin n_fail++; $display("FAIL sim_commit_drop: got min %0d field %0d expected 20 0", set_minutes, edit_field); end
    endtask

    task automatic test_repeat();
        cur_hours = 5'd9;
        cur_minutes = 6'd5;
        press(1, 0, 0, 1, 3);
        press(1, 0, 0, 20, 3);
        n_chk++; if (edit_field !== 2'd2) begin n_fail++; $display("FAIL rpt_mode_hold: got %0d expected 2", edit_field); end
        press(0, 1, 0, 9, 3);
        n_chk++; if (set_minutes !== 6'd8) begin n_fail++; $display("FAIL rpt_inc9: got %0d expected 8", set_minutes); end
        press(0, 0, 1, 5, 3);
        n_chk++; if (set_minutes !== 6'd6) begin n_fail++; $display("FAIL rpt_dec5: got %0d expected 6", set_minutes); end
        press(1, 0, 0, 1, 3);
        n_chk++; if (flag_h !== 9 || flag_m !== 6) begin n_fail++; $display("FAIL rpt_commit: got %0d:%0d expected 9:6", flag_h, flag_m); end
    endtask

    task automatic test_random();
        int st, h, m, exp_flags, op, hold, gap, steps;
        bit known;
        st = 0; h = 0; m = 0; known = 1'b0;
        exp_flags = flag_cnt;
        for (int n = 0; n < 60; n++) begin
            op = (n == 0) ? 0 : $urandom_range(0, 9);
            hold = (op == 9) ? 1 : $urandom_range(1, 10);
            gap = $urandom_range(3, 6);
            cur_hours = 5'($urandom_range(0, 31));
            cur_minutes = 6'($urandom_range(0, 63));
            steps = 1 + (hold - 1) / R;
            if (op <= 2) begin
                if (st == 0) begin
                    h = (int'(cur_hours) > 23) ? 0 : int'(cur_hours);
                    m = (int'(cur_minutes) > 59) ? 0 : int'(cur_minutes);
                    st = 1;
                    known = 1'b1;
                end else if (st == 1) begin
                    st = 2;
                end else begin
                    st = 0;
                    exp_flags++;
                end
                press(1, 0, 0, hold, gap);
            end else if (op <= 8) begin
                if (st == 1) h = wrap(h, (op <= 5) ? steps : -steps, 24);
                if (st == 2) m = wrap(m, (op <= 5) ? steps : -steps, 60);
                press(0, op <= 5, op > 5, hold, gap);
            end else begin
                press(0, 1, 1, 1, gap);
            end
            n_chk++; if (edit_field !== 2'(st)) begin n_fail++; $display("FAIL rnd_field[%0d]: got %0d expected %0d", n, edit_field, st); end
            n_chk++; if (flag_cnt !== exp_flags) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %0d expected %0d", n, flag_cnt, exp_flags); end
            if (known) begin
                n_chk++; if (int'(set_hours) !== h || int'(set_minutes) !== m) begin
                    n_fail++; $display("FAIL rnd_value[%0d]: got %0d:%0d expected %0d:%0d", n, set_hours, set_minutes, h, m);
                end
            end
            if (op <= 2 && st == 0) begin
                n_chk++; if (flag_h !== h || flag_m !== m || pre_h !== h || pre_m !== m || post_h !== h || post_m !== m) begin
                    n_fail++; $display("FAIL rnd_commit[%0d]: got %0d:%0d pre %0d:%0d post %0d:%0d expected %0d:%0d",
                                       n, flag_h, flag_m, pre_h, pre_m, post_h, post_m, h, m);
                end
            end
        end
        n_chk++; if (dbl_cnt !== 0) begin n_fail++; $display("FAIL flag_width: got %0d multi-cycle strobes expected 0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_edit();
        test_sequence();
        test_wrap();
        test_timeout();
        test_simultaneous();
        test_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
